// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: request/grant handshake plus read-response channel.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request/grant/response memory transaction per start, store alignment, load extension.
// Latency: store 2 cycles, load 3 cycles, illegal/misaligned 1 cycle; each cycle without grant or rvalid adds one.
// Backpressure: request held stable until mem_gnt; watchdog aborts with err after TIMEOUT cycles in REQ+WAIT.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    load_store_unit_if.master mem_bus
);
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam int         CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    typedef struct packed {
        logic       is_load;
        logic [2:0] f3;
        logic [1:0] off;
    } lat_t;

    state_t        state;
    lat_t          lat;
    logic [CW-1:0] cnt;

    logic        is_load_op;
    logic        is_store_op;
    logic        legal;
    logic        misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        wd_expire;

    always_comb begin
        is_load_op  = (opcode == OP_LOAD);
        is_store_op = (opcode == OP_STORE);
        legal       = 1'b0;
        if (is_load_op)
            legal = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store_op)
            legal = func3 inside {3'b000, 3'b001, 3'b010};
        misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                     ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

        st_strb = 4'b0000;
        st_data = '0;
        case (func3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {addr[1], 1'b0};
                st_data = {2{store_data[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = store_data;
            end
        endcase
    end

    // Extraction uses the latched offset/width, never the live core inputs.
    always_comb begin
        ld_byte = mem_bus.mem_rdata[{lat.off, 3'b000} +: 8];
        ld_half = mem_bus.mem_rdata[{lat.off[1], 4'b0000} +: 16];
        case (lat.f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_bus.mem_rdata;
        endcase
        wd_expire = (TIMEOUT != 0) && (cnt == WD_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            lat               <= '0;
            cnt               <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            load_data         <= '0;
            mem_bus.mem_req   <= 1'b0;
            mem_bus.mem_we    <= 1'b0;
            mem_bus.mem_addr  <= '0;
            mem_bus.mem_wstrb <= '0;
            mem_bus.mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat  <= '{is_load: is_load_op, f3: func3, off: addr[1:0]};
                        busy <= 1'b1;
                        if (!legal || misaligned) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state             <= REQ;
                            cnt               <= '0;
                            mem_bus.mem_req   <= 1'b1;
                            mem_bus.mem_we    <= is_store_op;
                            mem_bus.mem_addr  <= {addr[31:2], 2'b00};
                            mem_bus.mem_wstrb <= is_store_op ? st_strb : 4'b0000;
                            mem_bus.mem_wdata <= is_store_op ? st_data : 32'h0;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    // A grant in the expiry cycle still completes the transfer.
                    if (mem_bus.mem_gnt) begin
                        mem_bus.mem_req <= 1'b0;
                        if (lat.is_load) begin
                            state <= WAIT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        mem_bus.mem_req <= 1'b0;
                        state           <= DONE;
                        done            <= 1'b1;
                        err             <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_bus.mem_rvalid) begin
                        load_data <= ld_ext;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else if (wd_expire) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan steps then randomized transactions against an arithmetic reference model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_t;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr, store_data;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic        busy_t, done_t, err_t;
    logic [31:0] load_data_t;
    logic [31:0] ld_model;
    int          n_cmp = 0;
    int          n_err = 0;

    load_store_unit_if bus();
    load_store_unit_if bus_t();

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .func3(func3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .err(err), .load_data(load_data), .mem_bus(bus)
    );

    load_store_unit #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .start(start_t), .opcode(opcode), .func3(func3),
        .addr(addr), .store_data(store_data), .busy(busy_t), .done(done_t),
        .err(err_t), .load_data(load_data_t), .mem_bus(bus_t)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input logic [4:0] op, input logic [2:0] f3);
        if (op == 5'b00000) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if (op == 5'b01000) return f3 <= 3'd2;
        return 1'b0;
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s = 4'b0000;
        int sz = m_size(f3);
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sz) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w = '0;
        int sz = m_size(f3);
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = m_size(f3);
        int off = int'(a % 4);
        logic [31:0] v = rd >> (8 * off);
        logic [31:0] mask;
        if (sz < 4) begin
            mask = 32'((64'd1 << (8 * sz)) - 64'd1);
            v = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Drives one transaction on the main DUT and checks every cycle against the model.
    task automatic run_txn(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int gd, input int rd, input logic [31:0] rdat);
        bit ld, ok;
        logic [31:0] ea;
        ld = (op == 5'b00000);
        ok = m_legal(op, f3) && !m_misaligned(f3, a);
        ea = {a[31:2], 2'b00};
        opcode = op; func3 = f3; addr = a; store_data = sd; start = 1'b1;
        step();
        start = 1'b0;
        opcode = 5'($urandom()); func3 = 3'($urandom()); addr = $urandom(); store_data = $urandom();
        if (!ok) begin
            chk("ill_done", 32'(done), 32'd1);
            chk("ill_err", 32'(err), 32'd1);
            chk("ill_req", 32'(bus.mem_req), 32'd0);
            chk("ill_ld", load_data, ld_model);
            step();
            chk("ill_idle", 32'({busy, done, err, bus.mem_req}), 32'd0);
            return;
        end
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_req", 32'(bus.mem_req), 32'd1);
        chk("req_we", 32'(bus.mem_we), 32'(!ld));
        chk("req_addr", bus.mem_addr, ea);
        chk("req_strb", 32'(bus.mem_wstrb), ld ? 32'd0 : 32'(m_strb(f3, a)));
        if (!ld) chk("req_wdata", bus.mem_wdata, m_wdata(f3, sd));
        for (int k = 0; k < gd; k++) begin
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom();
            step();
            chk("stall_req", 32'(bus.mem_req), 32'd1);
            chk("stall_addr", bus.mem_addr, ea);
            chk("stall_done", 32'(done), 32'd0);
        end
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom();
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        chk("gnt_req", 32'(bus.mem_req), 32'd0);
        if (!ld) begin
            chk("st_done", 32'(done), 32'd1);
            chk("st_err", 32'(err), 32'd0);
            chk("st_ld", load_data, ld_model);
        end else begin
            chk("wait_done", 32'(done), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            for (int k = 0; k < rd; k++) begin
                step();
                chk("wait_stall", 32'(done), 32'd0);
            end
            bus.mem_rvalid = 1'b1; bus.mem_rdata = rdat;
            step();
            bus.mem_rvalid = 1'b0;
            ld_model = m_load(f3, a, rdat);
            chk("ld_done", 32'(done), 32'd1);
            chk("ld_err", 32'(err), 32'd0);
            chk("ld_data", load_data, ld_model);
        end
        step();
        chk("end_idle", 32'({busy, done, err}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_t = 1'b0;
        opcode = '0; func3 = '0; addr = '0; store_data = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus_t.mem_gnt = 1'b0; bus_t.mem_rvalid = 1'b0; bus_t.mem_rdata = '0;
        ld_model = '0;
        step();
        step();
        chk("rst_ctl", 32'({busy, done, err, bus.mem_req, bus.mem_we}), 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_strb", 32'(bus.mem_wstrb), 32'd0);
        rst = 1'b0;
        step();

        run_txn(5'b01000, 3'b000, 32'h0000_1003, 32'hA5A5_12EF, 0, 0, 32'h0);
        run_txn(5'b00000, 3'b000, 32'h0000_2002, 32'h0, 0, 0, 32'h1280_3456);
        chk("lb_const", load_data, 32'hFFFF_FF80);
        run_txn(5'b00000, 3'b100, 32'h0000_2002, 32'h0, 0, 0, 32'h1280_3456);
        chk("lbu_const", load_data, 32'h0000_0080);
        run_txn(5'b00000, 3'b001, 32'h0000_2001, 32'h0, 0, 0, 32'h0);
        chk("lh_mis_keep", load_data, 32'h0000_0080);
        run_txn(5'b00000, 3'b010, 32'h0000_4000, 32'h0, 3, 1, 32'hDEAD_BEEF);
        chk("lw_const", load_data, 32'hDEAD_BEEF);
        run_txn(5'b00100, 3'b000, 32'h0000_4000, 32'h0, 0, 0, 32'h0);
        run_txn(5'b01000, 3'b001, 32'h0000_5002, 32'h1234_CAFE, 1, 0, 32'h0);

        // Watchdog on the TIMEOUT=4 instance: grant never comes.
        opcode = 5'b00000; func3 = 3'b010; addr = 32'h0000_3000; start_t = 1'b1;
        step();
        start_t = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("to_req", 32'(bus_t.mem_req), 32'd1);
            chk("to_nodone", 32'(done_t), 32'd0);
            step();
        end
        chk("to_done", 32'(done_t), 32'd1);
        chk("to_err", 32'(err_t), 32'd1);
        chk("to_drop", 32'(bus_t.mem_req), 32'd0);
        chk("to_ld", load_data_t, 32'd0);
        step();
        chk("to_idle", 32'(busy_t), 32'd0);
        opcode = 5'b01000; func3 = 3'b010; addr = 32'h0000_3004; store_data = 32'h0BAD_F00D; start_t = 1'b1;
        step();
        start_t = 1'b0;
        chk("to_next_req", 32'(bus_t.mem_req), 32'd1);
        chk("to_next_wd", bus_t.mem_wdata, 32'h0BAD_F00D);
        bus_t.mem_gnt = 1'b1;
        step();
        bus_t.mem_gnt = 1'b0;
        chk("to_next_done", 32'({done_t, err_t}), 32'd2);
        step();

        // Reset asserted while a load waits for rvalid.
        opcode = 5'b00000; func3 = 3'b010; addr = 32'h0000_6000; start = 1'b1;
        step();
        start = 1'b0;
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        chk("rw_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rw_ctl", 32'({busy, done, err, bus.mem_req, bus.mem_we}), 32'd0);
        chk("rw_ld", load_data, 32'd0);
        chk("rw_addr", bus.mem_addr, 32'd0);
        ld_model = '0;
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        step();
        bus.mem_rvalid = 1'b0;
        chk("rw_late_done", 32'(done), 32'd0);
        chk("rw_late_ld", load_data, 32'd0);
        step();

        for (int n = 0; n < 40; n++) begin
            int sel;
            logic [4:0] op;
            sel = int'($urandom_range(0, 9));
            op = (sel < 4) ? 5'b00000 : (sel < 8) ? 5'b01000 : 5'($urandom());
            run_txn(op, 3'($urandom()), $urandom(), $urandom(),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
